// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants, event type and capture-state encoding for
//                the PS/2 key decoder and its event FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Prefix bytes folded into a single key event
  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  // Keyboard control / status bytes that never describe a key
  localparam logic [7:0] PS2_CTL_ERR0   = 8'h00;
  localparam logic [7:0] PS2_CTL_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_CTL_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_CTL_ACK    = 8'hFA;
  localparam logic [7:0] PS2_CTL_RESEND = 8'hFE;
  localparam logic [7:0] PS2_CTL_ERR1   = 8'hFF;

  // Pause make sequence is E1 followed by seven more bytes
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_key_ev_t;

  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_CAPTURE  = 2'd1,
    CAP_WAIT_LOW = 2'd2
  } cap_state_t;

  function automatic logic is_ctrl_code(input logic [7:0] b);
    return (b == PS2_CTL_ERR0)   || (b == PS2_CTL_BAT_OK) ||
           (b == PS2_CTL_ECHO)   || (b == PS2_CTL_ACK)    ||
           (b == PS2_CTL_RESEND) || (b == PS2_CTL_ERR1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ev_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ev_fifo
//  Description : Synchronous FIFO of key events. Head is read straight out of
//                registered storage; empty is a flop so ev_valid is clean.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_ev_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  ps2_key_ev_t              push_ev,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output ps2_key_ev_t              head
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  ps2_key_ev_t   mem_q [DEPTH];
  ps2_key_ev_t   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Accept a push when there is room, or when the head leaves this same cycle
  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & ((count_q < DEPTH_C) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_ev;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
  end

  // Storage, pointers and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  assign full  = (count_q == DEPTH_C);
  assign empty = empty_q;
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Consumes received PS/2 bytes, folds E0/F0 prefixes into one
//                key event, drops control bytes and Pause sequences, and
//                queues events for the consumer over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_success,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYC);

  cap_state_t    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          rx_success_q, rx_success_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overflow_q, overflow_d;

  logic          pending, expired, ext_eff, brk_eff;
  logic          push, pop;
  ps2_key_ev_t   push_ev;
  ps2_key_ev_t   head;
  logic          fifo_full, fifo_empty;
  // Occupancy is not needed by the decoder itself
  logic [$clog2(DEPTH):0] fifo_count_unused;

  // Capture state register plus the latched byte and acknowledge flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CAP_IDLE;
      byte_q       <= '0;
      rx_success_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      rx_success_q <= rx_success_d;
    end
  end

  // Capture FSM: one acknowledge per rx_done level, however long it is held
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    rx_success_d = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (rx_done) begin
          state_d      = CAP_CAPTURE;
          byte_d       = rx_data;
          rx_success_d = 1'b1;
        end
      end
      CAP_CAPTURE:  state_d = CAP_WAIT_LOW;
      CAP_WAIT_LOW: if (!rx_done) state_d = CAP_IDLE;
      default:      state_d = CAP_IDLE;
    endcase
  end

  // Prefix flags, Pause skip counter, prefix timeout and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      skip_q     <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      skip_q     <= skip_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte decode during CAPTURE; an expired prefix no longer qualifies the byte
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    skip_d     = skip_q;
    timer_d    = timer_q;
    push       = 1'b0;
    push_ev    = '0;

    pending = ext_pend_q | brk_pend_q;
    expired = pending & (timer_q == TIMEOUT_C);
    ext_eff = ext_pend_q & ~expired;
    brk_eff = brk_pend_q & ~expired;

    if (expired) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      timer_d    = '0;
    end else if (pending) begin
      timer_d = timer_q + TW'(1);
    end

    if (state_q == CAP_CAPTURE) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_q == PS2_PFX_PAUSE) begin
        skip_d     = PS2_PAUSE_SKIP;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        timer_d    = '0;
      end else if (byte_q == PS2_PFX_EXT) begin
        ext_pend_d = 1'b1;
        brk_pend_d = brk_eff;
        timer_d    = '0;
      end else if (byte_q == PS2_PFX_BRK) begin
        brk_pend_d = 1'b1;
        ext_pend_d = ext_eff;
        timer_d    = '0;
      end else if (is_ctrl_code(byte_q) && !(ext_eff || brk_eff)) begin
        // Keyboard status byte outside any key sequence: nothing to report
        skip_d = skip_q;
      end else begin
        push         = 1'b1;
        push_ev.code = byte_q;
        push_ev.ext  = ext_eff;
        push_ev.brk  = brk_eff;
        ext_pend_d   = 1'b0;
        brk_pend_d   = 1'b0;
        timer_d      = '0;
      end
    end

    pop        = ~fifo_empty & ev_ready;
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  ps2_ev_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_ev (push_ev),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused),
    .head    (head)
  );

  assign rx_success = rx_success_q;
  assign ev_valid   = ~fifo_empty;
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_break   = head.brk;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire
